// File: rtl/alu.sv
// K16 datapath ALU: registered arithmetic/logic, shift/rotate and load/format
// unit with carry/zero/negative flags and one-cycle latency.
// Optional macro ALU_OVERFLOW_EN adds a registered signed-overflow flag.
module alu #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] operand1,
    input  logic [WIDTH-1:0] operand2,
    input  logic             carryIn,
    input  logic [2:0]       operation,
    input  logic             enableAlu,
    input  logic             enableShift,
    input  logic             enableLoad,
    output logic [WIDTH-1:0] result,
    output logic             carryOut,
    output logic             zeroOut,
`ifdef ALU_OVERFLOW_EN
    output logic             overflowOut,
`endif
    output logic             negativeOut
);

    localparam int H = WIDTH / 2;

    logic [WIDTH-1:0] result_q, result_d;
    logic             carry_q, carry_d;
    logic             zero_q, zero_d;
    logic             neg_q, neg_d;
    logic             ovf_q, ovf_d;

    // Adder shared by ADD/ADC/SUB/SBC: op[1] inverts op2, op[0] selects carryIn
    // as carry-in, otherwise carry-in is 1 for SUB and 0 for ADD.
    logic [WIDTH-1:0] add_b;
    logic             add_ci;
    logic [WIDTH:0]   add_sum;

    // Adder operand selection and sum
    always_comb begin
        add_b   = operation[1] ? ~operand2 : operand2;
        add_ci  = operation[0] ? carryIn : operation[1];
        add_sum = {1'b0, operand1} + {1'b0, add_b} + {{WIDTH{1'b0}}, add_ci};
    end

    // Next-state selection by group priority; no enable holds everything
    always_comb begin
        result_d = result_q;
        carry_d  = carry_q;
        zero_d   = zero_q;
        neg_d    = neg_q;
        ovf_d    = ovf_q;
        if (enableAlu) begin
            ovf_d = 1'b0;
            case (operation)
                3'd0, 3'd1, 3'd2, 3'd3: begin
                    result_d = add_sum[WIDTH-1:0];
                    carry_d  = add_sum[WIDTH];
                    // With op2 already inverted for subtraction, one rule covers both.
                    ovf_d    = (operand1[WIDTH-1] == add_b[WIDTH-1]) &&
                               (add_sum[WIDTH-1] != operand1[WIDTH-1]);
                end
                3'd4:    begin result_d = operand1 & operand2; carry_d = 1'b0; end
                3'd5:    begin result_d = operand1 | operand2; carry_d = 1'b0; end
                3'd6:    begin result_d = operand1 ^ operand2; carry_d = 1'b0; end
                default: begin result_d = ~operand1;           carry_d = 1'b0; end
            endcase
        end else if (enableShift) begin
            ovf_d = 1'b0;
            case (operation)
                3'd0: begin result_d = {1'b0, operand1[WIDTH-1:1]};               carry_d = operand1[0]; end
                3'd1: begin result_d = {operand1[WIDTH-2:0], 1'b0};               carry_d = operand1[WIDTH-1]; end
                3'd2: begin result_d = {operand1[WIDTH-1], operand1[WIDTH-1:1]};  carry_d = operand1[0]; end
                3'd3: begin result_d = {operand1[0], operand1[WIDTH-1:1]};        carry_d = operand1[0]; end
                3'd4: begin result_d = {operand1[WIDTH-2:0], operand1[WIDTH-1]};  carry_d = operand1[WIDTH-1]; end
                default: begin result_d = operand1;                               carry_d = carryIn; end
            endcase
        end else if (enableLoad) begin
            ovf_d   = 1'b0;
            carry_d = carryIn;
            case (operation)
                3'd0:       result_d = operand1;
                3'd1, 3'd6: result_d = {operand2[WIDTH-1:H], operand1[H-1:0]};
                3'd2, 3'd7: result_d = {operand1[H-1:0], operand2[H-1:0]};
                3'd3:       result_d = {operand1[H-1:0], operand1[WIDTH-1:H]};
                3'd4:       result_d = {{H{1'b0}}, operand1[H-1:0]};
                default:    result_d = {{H{operand1[H-1]}}, operand1[H-1:0]};
            endcase
        end
        if (enableAlu || enableShift || enableLoad) begin
            zero_d = (result_d == '0);
            neg_d  = result_d[WIDTH-1];
        end
    end

    // Output and flag registers, cleared asynchronously
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            result_q <= '0;
            carry_q  <= 1'b0;
            zero_q   <= 1'b0;
            neg_q    <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            result_q <= result_d;
            carry_q  <= carry_d;
            zero_q   <= zero_d;
            neg_q    <= neg_d;
            ovf_q    <= ovf_d;
        end
    end

    assign result      = result_q;
    assign carryOut    = carry_q;
    assign zeroOut     = zero_q;
    assign negativeOut = neg_q;
`ifdef ALU_OVERFLOW_EN
    assign overflowOut = ovf_q;
`else
    // Overflow tracking is only exposed when the feature is enabled.
    logic unused_ovf;
    assign unused_ovf = ovf_q;
`endif

endmodule

// File: tb/tb_alu.sv
// Directed self-checking bench for the K16 ALU.
module tb_alu;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] operand1, operand2;
    logic        carryIn;
    logic [2:0]  operation;
    logic        enableAlu, enableShift, enableLoad;
    logic [15:0] result;
    logic        carryOut, zeroOut, negativeOut;
`ifdef ALU_OVERFLOW_EN
    logic        overflowOut;
`endif

    int total = 0;
    int bad   = 0;

    alu #(.WIDTH(16)) dut (
        .clk         (clk),
        .reset       (reset),
        .operand1    (operand1),
        .operand2    (operand2),
        .carryIn     (carryIn),
        .operation   (operation),
        .enableAlu   (enableAlu),
        .enableShift (enableShift),
        .enableLoad  (enableLoad),
        .result      (result),
        .carryOut    (carryOut),
        .zeroOut     (zeroOut),
`ifdef ALU_OVERFLOW_EN
        .overflowOut (overflowOut),
`endif
        .negativeOut (negativeOut)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [15:0] r, input logic c,
                           input logic z, input logic n);
        chk({tag, ".res"}, result, r);
        chk({tag, ".c"}, {15'd0, carryOut}, {15'd0, c});
        chk({tag, ".z"}, {15'd0, zeroOut}, {15'd0, z});
        chk({tag, ".n"}, {15'd0, negativeOut}, {15'd0, n});
    endtask

    // Apply one operation and sample 1 time unit after the capturing edge.
    task automatic step(input logic ea, input logic es, input logic el, input logic [2:0] op,
                        input logic [15:0] a, input logic [15:0] b, input logic ci);
        enableAlu = ea; enableShift = es; enableLoad = el;
        operation = op; operand1 = a; operand2 = b; carryIn = ci;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b0;
        enableAlu = 1'b1; enableShift = 1'b1; enableLoad = 1'b1;
        operation = 3'd6; operand1 = 16'h1234; operand2 = 16'h5678; carryIn = 1'b1;
        #1;
        chk_all("rst0", 16'h0000, 1'b0, 1'b0, 1'b0);
        @(posedge clk); @(posedge clk); #1;
        chk_all("rst_hold", 16'h0000, 1'b0, 1'b0, 1'b0);
`ifdef ALU_OVERFLOW_EN
        chk("rst_ovf", {15'd0, overflowOut}, 16'd0);
`endif
        @(negedge clk);
        reset = 1'b1;

        // Arithmetic
        step(1, 0, 0, 3'd0, 16'hFFFF, 16'h0001, 1'b0);
        chk_all("add_wrap", 16'h0000, 1'b1, 1'b1, 1'b0);
        step(1, 0, 0, 3'd2, 16'h0005, 16'h0007, 1'b0);
        chk_all("sub_neg", 16'hFFFE, 1'b0, 1'b0, 1'b1);
        step(1, 0, 0, 3'd3, 16'h0010, 16'h0001, 1'b1);
        chk_all("sbc", 16'h000F, 1'b1, 1'b0, 1'b0);
        step(1, 0, 0, 3'd1, 16'h0001, 16'h0002, 1'b1);
        chk_all("adc", 16'h0004, 1'b0, 1'b0, 1'b0);
        step(1, 0, 0, 3'd6, 16'hF0F0, 16'hFF00, 1'b1);
        chk_all("xor", 16'h0FF0, 1'b0, 1'b0, 1'b0);
        step(1, 0, 0, 3'd7, 16'h00FF, 16'h0000, 1'b1);
        chk_all("not", 16'hFF00, 1'b0, 1'b0, 1'b1);

        // Shift / rotate
        step(0, 1, 0, 3'd0, 16'h8001, 16'h0000, 1'b0);
        chk_all("shr", 16'h4000, 1'b1, 1'b0, 1'b0);
        step(0, 1, 0, 3'd2, 16'h8001, 16'h0000, 1'b0);
        chk_all("ashr", 16'hC000, 1'b1, 1'b0, 1'b1);
        step(0, 1, 0, 3'd4, 16'h8001, 16'h0000, 1'b0);
        chk_all("rol", 16'h0003, 1'b1, 1'b0, 1'b0);
        step(0, 1, 0, 3'd1, 16'h8001, 16'h0000, 1'b0);
        chk_all("shl", 16'h0002, 1'b1, 1'b0, 1'b0);
        step(0, 1, 0, 3'd3, 16'h8001, 16'h0000, 1'b0);
        chk_all("ror", 16'hC000, 1'b1, 1'b0, 1'b1);
        step(0, 1, 0, 3'd5, 16'h8001, 16'h0000, 1'b0);
        chk_all("sh_pass", 16'h8001, 1'b0, 1'b0, 1'b1);

        // Load / format
        step(0, 0, 1, 3'd3, 16'h1234, 16'hABCD, 1'b1);
        chk_all("swp", 16'h3412, 1'b1, 1'b0, 1'b0);
        step(0, 0, 1, 3'd1, 16'h1234, 16'hABCD, 1'b1);
        chk_all("ldl", 16'hAB34, 1'b1, 1'b0, 1'b1);
        step(0, 0, 1, 3'd2, 16'h1234, 16'hABCD, 1'b1);
        chk_all("ldh", 16'h34CD, 1'b1, 1'b0, 1'b0);
        step(0, 0, 1, 3'd5, 16'h0080, 16'hABCD, 1'b1);
        chk_all("ldis", 16'hFF80, 1'b1, 1'b0, 1'b1);
        step(0, 0, 1, 3'd4, 16'h12F0, 16'hABCD, 1'b0);
        chk_all("ldi", 16'h00F0, 1'b0, 1'b0, 1'b0);
        step(0, 0, 1, 3'd0, 16'h0000, 16'hABCD, 1'b1);
        chk_all("ld_zero", 16'h0000, 1'b1, 1'b1, 1'b0);

        // Group priority
        step(1, 1, 0, 3'd0, 16'h0001, 16'h0001, 1'b0);
        chk_all("prio_alu", 16'h0002, 1'b0, 1'b0, 1'b0);
        step(0, 1, 1, 3'd3, 16'h0001, 16'h0000, 1'b0);
        chk_all("prio_shift", 16'h8000, 1'b1, 1'b0, 1'b1);

        // No enable: hold
        step(0, 0, 0, 3'd0, 16'h0000, 16'h0000, 1'b0);
        chk_all("hold1", 16'h8000, 1'b1, 1'b0, 1'b1);
        step(0, 0, 0, 3'd7, 16'h5555, 16'hAAAA, 1'b1);
        chk_all("hold2", 16'h8000, 1'b1, 1'b0, 1'b1);
        step(0, 0, 0, 3'd2, 16'hFFFF, 16'h0001, 1'b0);
        chk_all("hold3", 16'h8000, 1'b1, 1'b0, 1'b1);

`ifdef ALU_OVERFLOW_EN
        step(1, 0, 0, 3'd0, 16'h7FFF, 16'h0001, 1'b0);
        chk_all("ovf_add", 16'h8000, 1'b0, 1'b0, 1'b1);
        chk("ovf_add.v", {15'd0, overflowOut}, 16'd1);
        step(1, 0, 0, 3'd2, 16'h8000, 16'h0001, 1'b0);
        chk_all("ovf_sub", 16'h7FFF, 1'b1, 1'b0, 1'b0);
        chk("ovf_sub.v", {15'd0, overflowOut}, 16'd1);
        step(0, 0, 0, 3'd0, 16'h0000, 16'h0000, 1'b0);
        chk("ovf_hold", {15'd0, overflowOut}, 16'd1);
        step(1, 0, 0, 3'd2, 16'h0005, 16'h0003, 1'b0);
        chk("ovf_sub_none", {15'd0, overflowOut}, 16'd0);
        step(1, 0, 0, 3'd0, 16'h7FFF, 16'h0001, 1'b0);
        chk("ovf_add2", {15'd0, overflowOut}, 16'd1);
        step(0, 1, 0, 3'd1, 16'h4000, 16'h0000, 1'b0);
        chk("ovf_shift_clr", {15'd0, overflowOut}, 16'd0);
        step(1, 0, 0, 3'd0, 16'h7FFF, 16'h0001, 1'b0);
`else
        step(1, 0, 0, 3'd0, 16'h7FFF, 16'h0001, 1'b0);
        chk_all("add_7fff", 16'h8000, 1'b0, 1'b0, 1'b1);
`endif

        // Asynchronous reset mid-cycle, pending op discarded
        enableAlu = 1'b1; operation = 3'd0; operand1 = 16'h0003; operand2 = 16'h0004;
        #2;
        reset = 1'b0;
        #1;
        chk_all("arst", 16'h0000, 1'b0, 1'b0, 1'b0);
`ifdef ALU_OVERFLOW_EN
        chk("arst_ovf", {15'd0, overflowOut}, 16'd0);
`endif
        @(posedge clk); #1;
        chk_all("arst_hold", 16'h0000, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        step(1, 0, 0, 3'd0, 16'h0003, 16'h0004, 1'b0);
        chk_all("post_rst", 16'h0007, 1'b0, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu.md
Name: alu

Overview:
- Registered WIDTH-bit arithmetic/logic, shift and load/immediate-formatting unit for the K16 CPU datapath.
- One of three operation groups is selected by one-hot-style enables, with a 3-bit sub-operation code.
- Produces the result plus carry/zero/negative flags, all registered with one-cycle latency.
- The CPU writes the result to its register file and the flags to its status bits.

Parameters:
- WIDTH, 16, datapath width. Must be even and >= 4. "Low half" means bits [WIDTH/2-1:0]; "high half" means [WIDTH-1:WIDTH/2].

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset (asserted when 0)
- operand1  input  WIDTH  first operand; immediate source for load ops
- operand2  input  WIDTH  second operand; merge source for byte loads
- carryIn  input  1  current carry flag
- operation  input  3  sub-operation code within the selected group
- enableAlu  input  1  select arithmetic/logic group
- enableShift  input  1  select shift/rotate group
- enableLoad  input  1  select load/format group
- result  output  WIDTH  registered result
- carryOut  output  1  registered carry
- zeroOut  output  1  registered zero flag
- negativeOut  output  1  registered negative flag

Behaviour:
- Reset (reset==0, asynchronous): result=0, carryOut=0, zeroOut=0, negativeOut=0. Outputs hold these values while reset stays low.
- Group priority: enableAlu > enableShift > enableLoad.
- No enable asserted: all outputs hold their previous values. There is no capture.
- Latency: inputs sampled on a rising clk edge appear on the outputs after that same edge (1 cycle). A new operation may be issued every cycle.
- Flag rules:
  - zeroOut = (new result == 0).
  - negativeOut = new result[WIDTH-1].
  - carryOut is defined per group below.
- ALU group:
  - 0 ADD: op1+op2. C = carry out of bit WIDTH-1.
  - 1 ADC: op1+op2+carryIn. C = carry out of bit WIDTH-1.
  - 2 SUB: op1+~op2+1. C = carry out (1 = no borrow).
  - 3 SBC: op1+~op2+carryIn. C = carry out (1 = no borrow).
  - 4 AND, 5 OR, 6 XOR: bitwise op1 with op2. C=0.
  - 7 NOT: ~op1. C=0.
  - Sums wrap modulo 2^WIDTH.
- Shift group (operand1 only):
  - 0 SHR: logical right. C = op1[0].
  - 1 SHL: left, zero fill. C = op1[WIDTH-1].
  - 2 ASHR: right, MSB replicated. C = op1[0].
  - 3 ROR: C = op1[0]; result MSB = op1[0].
  - 4 ROL: C = op1[WIDTH-1]; result LSB = op1[WIDTH-1].
  - 5,6,7: pass op1 unchanged. C = carryIn.
- Load group (C = carryIn for all):
  - 0 LD: op1.
  - 1 LDL: {op2 high, op1 low}.
  - 2 LDH: {op1 low, op2 low}.
  - 3 SWP: {op1 low, op1 high}.
  - 4 LDI: zero-extend op1 low.
  - 5 LDIS: sign-extend op1 low.
  - 6 LDIL: {op2 high, op1 low}.
  - 7 LDIH: {op1 low, op2 low}.
- Multiple enables asserted: only the highest-priority group executes. This is not an error.
- Reset asserted mid-stream: pending operation is discarded. The first operation after release is captured on the first rising edge with reset==1.
- The block never writes the CPU register file and has no other state.

Optional Feature:
- Macro ALU_OVERFLOW_EN.
- When defined:
  - Adds output port overflowOut (1 bit), registered alongside the other flags.
  - Reset value 0.
  - ADD/ADC: set when both operands have equal sign and the result sign differs.
  - SUB/SBC: set when the operand signs differ and the result sign differs from op1.
  - All other operations: 0.
  - Holds when no enable is asserted.
- When undefined: port absent; all other behaviour identical.

Test Plan:
1. Reset low with stale inputs -> all outputs 0. Release, then enableAlu, op=0, 0xFFFF+0x0001 -> next edge result=0x0000, C=1, Z=1, N=0.
2. enableAlu, op=2, 0x0005-0x0007 -> result 0xFFFE, C=0, N=1. Then op=3 (SBC), carryIn=1, 0x0010-0x0001 -> 0x000F, C=1.
3. enableShift, op1=0x8001 -> op 0 SHR: 0x4000, C=1. Op 2 ASHR: 0xC000, C=1. Op 4 ROL: 0x0003, C=1. Op 1 SHL: 0x0002, C=1.
4. enableLoad, op1=0x1234, op2=0xABCD -> op 3 SWP: 0x3412. Op 1 LDL: 0xAB34. Op 2 LDH: 0x34CD. Op 5 LDIS with op1=0x0080: 0xFF80, N=1. carryOut = carryIn.
5. Enables: enableAlu+enableShift both 1, op=0, 0x0001+0x0001 -> 0x0002 (ALU wins). Then all enables 0 with new operands for 3 cycles -> outputs unchanged.
6. ALU_OVERFLOW_EN build: 0x7FFF+0x0001 -> 0x8000, overflowOut=1. Then 0x8000-0x0001 -> 0x7FFF, overflowOut=1. Reset pulsed mid-sequence -> all outputs 0 asynchronously.
